csr_mult_pipe: RTL and testbench

Parametrised, two-stage pipelined unsigned/signed multiplier built on carry-save reduction. It generalises the fixed 6-bit carry-save multiplier to a WIDTH-bit operand size, registers the carry-save vectors between reduction and the carry-propagate adder, and adds a valid/ready handshake with full backpressure. It sits between operand sources (register file / DSP datapath) and any consumer that can stall.

---
 rtl/csr_mult_pkg.sv | 20 ++
 rtl/Half_Adder.sv | 10 +
 rtl/csr_reduce_tree.sv | 82 ++++++++
 rtl/full_adder.sv | 11 +
 rtl/csr_mult_pipe.sv | 88 ++++++++
 tb/tb_csr_mult_pipe.sv | 268 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/csr_mult_pkg.sv
// Shared helpers for the pipelined carry-save multiplier (csr_mult_pipe).
// Signed Baugh-Wooley support is compiled in with CSR_MULT_SIGNED_EN.
package csr_mult_pkg;

    function automatic int prodWidth(input int w);
        return 2 * w;
    endfunction

    // w partial-product rows plus one injection row (cin / correction constants),
    // each 3:2 step retires one row, so w+1 rows need w steps.
    function automatic int csaLevels(input int w);
        return w;
    endfunction

    typedef struct packed {
        logic s1;
        logic s2;
    } stageValid_t;

endpackage

// File: rtl/Half_Adder.sv
// Single-bit half adder cell.
module Half_Adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

// File: rtl/csr_reduce_tree.sv
// Partial-product generation and carry-save reduction to a sum/carry pair.
// CSR_MULT_SIGNED_EN adds the sgn input and Baugh-Wooley correction terms.
module csr_reduce_tree
    import csr_mult_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cin,
`ifdef CSR_MULT_SIGNED_EN
    input  logic               sgn,
`endif
    output logic [2*WIDTH-1:0] sum_v,
    output logic [2*WIDTH-1:0] carry_v
);
    localparam int PW     = prodWidth(WIDTH);
    localparam int LEVELS = csaLevels(WIDTH);

    logic [WIDTH-1:0][WIDTH-1:0] ppBits;
    logic [WIDTH:0][PW-1:0]      rowV;
    logic [LEVELS:1][PW-1:0]     sumV;
    logic [LEVELS:1][PW-1:0]     carryV;

    for (genvar j = 0; j < WIDTH; j++) begin : g_row
        for (genvar i = 0; i < WIDTH; i++) begin : g_col
`ifdef CSR_MULT_SIGNED_EN
            // Baugh-Wooley: cross terms touching exactly one sign bit are inverted.
            if ((i == WIDTH-1) != (j == WIDTH-1)) begin : g_bw
                assign ppBits[j][i] = (a[i] & b[j]) ^ sgn;
            end else begin : g_plain
                assign ppBits[j][i] = a[i] & b[j];
            end
`else
            assign ppBits[j][i] = a[i] & b[j];
`endif
        end
        assign rowV[j] = {{WIDTH{1'b0}}, ppBits[j]} << j;
    end

`ifdef CSR_MULT_SIGNED_EN
    localparam logic [PW-1:0] BW_CONST = (PW'(1) << WIDTH) | (PW'(1) << (PW-1));
    assign rowV[WIDTH] = {{(PW-1){1'b0}}, cin} | ({PW{sgn}} & BW_CONST);
`else
    assign rowV[WIDTH] = {{(PW-1){1'b0}}, cin};
`endif

    // Carries out of the top bit are dropped; the result is only needed mod 2^PW.
    for (genvar k = 0; k < PW; k++) begin : g_l1
        if (k < PW-1) begin : g_ha
            Half_Adder u_ha (
                .a    (rowV[0][k]),
                .b    (rowV[1][k]),
                .sum  (sumV[1][k]),
                .carry(carryV[1][k+1])
            );
        end else begin : g_top
            assign sumV[1][k] = rowV[0][k] ^ rowV[1][k];
        end
    end
    assign carryV[1][0] = 1'b0;

    for (genvar l = 2; l <= LEVELS; l++) begin : g_lvl
        for (genvar k = 0; k < PW; k++) begin : g_bit
            if (k < PW-1) begin : g_fa
                full_adder u_fa (
                    .a   (sumV[l-1][k]),
                    .b   (carryV[l-1][k]),
                    .cin (rowV[l][k]),
                    .sum (sumV[l][k]),
                    .cout(carryV[l][k+1])
                );
            end else begin : g_top
                assign sumV[l][k] = sumV[l-1][k] ^ carryV[l-1][k] ^ rowV[l][k];
            end
        end
        assign carryV[l][0] = 1'b0;
    end

    assign sum_v   = sumV[LEVELS];
    assign carry_v = carryV[LEVELS];
endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell (3:2 compressor).
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/csr_mult_pipe.sv
// Two-stage carry-save multiplier with valid/ready backpressure: s1 holds the
// carry-save pair, s2 holds the resolved product. CSR_MULT_SIGNED_EN adds sgn.
module csr_mult_pipe
    import csr_mult_pkg::*;
#(
    parameter  int WIDTH = 6,
    localparam int PW    = prodWidth(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CSR_MULT_SIGNED_EN
    input  logic             sgn,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    product
);
    logic [PW-1:0] sumV;
    logic [PW-1:0] carryV;
    logic [PW-1:0] cpaSum;
    logic          s1En;
    logic          s2En;

    stageValid_t   valid_q,    valid_d;
    logic [PW-1:0] s1Sum_q,    s1Sum_d;
    logic [PW-1:0] s1Carry_q,  s1Carry_d;
    logic [PW-1:0] product_q,  product_d;

    csr_reduce_tree #(.WIDTH(WIDTH)) u_tree (
        .a      (a),
        .b      (b),
        .cin    (cin),
`ifdef CSR_MULT_SIGNED_EN
        .sgn    (sgn),
`endif
        .sum_v  (sumV),
        .carry_v(carryV)
    );

    assign cpaSum = s1Sum_q + s1Carry_q;

    // A stage may load whenever its current content leaves (or it is empty).
    assign s2En     = !valid_q.s2 || out_ready;
    assign s1En     = !valid_q.s1 || s2En;
    assign in_ready = s1En;

    always_comb begin
        valid_d   = valid_q;
        s1Sum_d   = s1Sum_q;
        s1Carry_d = s1Carry_q;
        product_d = product_q;
        if (s1En) begin
            valid_d.s1 = in_valid;
        end
        if (s1En && in_valid) begin
            s1Sum_d   = sumV;
            s1Carry_d = carryV;
        end
        if (s2En) begin
            valid_d.s2 = valid_q.s1;
        end
        if (s2En && valid_q.s1) begin
            product_d = cpaSum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            s1Sum_q   <= '0;
            s1Carry_q <= '0;
            product_q <= '0;
        end else begin
            valid_q   <= valid_d;
            s1Sum_q   <= s1Sum_d;
            s1Carry_q <= s1Carry_d;
            product_q <= product_d;
        end
    end

    assign out_valid = valid_q.s2;
    assign product   = product_q;
endmodule

// File: tb/tb_csr_mult_pipe.sv
// Self-checking bench for csr_mult_pipe (WIDTH=6); signed cases run when
// CSR_MULT_SIGNED_EN is defined.
module tb_csr_mult_pipe;
    localparam int W  = 6;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          inValid;
    logic          inReady;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sgn;
    logic          outValid;
    logic          outReady;
    logic [PW-1:0] product;

    int total = 0;
    int bad   = 0;
    logic [PW-1:0] expQ[$];

    always #5 clk = ~clk;

    csr_mult_pipe #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (inValid),
        .in_ready (inReady),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef CSR_MULT_SIGNED_EN
        .sgn      (sgn),
`endif
        .out_valid(outValid),
        .out_ready(outReady),
        .product  (product)
    );

    // Reference: plain integer arithmetic, reduced mod 2^PW.
    function automatic logic [PW-1:0] refProduct(input logic [W-1:0] x, input logic [W-1:0] y,
                                                 input logic c, input logic s);
        longint xa, ya, full;
        if (s) begin
            xa = longint'($signed(x));
            ya = longint'($signed(y));
        end else begin
            xa = longint'(x);
            ya = longint'(y);
        end
        full = xa * ya + longint'(c);
        return full[PW-1:0];
    endfunction

    task automatic idleInputs();
        inValid = 1'b0;
        a = '0; b = '0; cin = 1'b0; sgn = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idleInputs();
        outReady = 1'b1;
        #2;
        total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b expected 0", outValid); end
        total++; if (product !== '0) begin bad++; $display("[TB] FAIL reset_product: got %0h expected 0", product); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        total++; if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b expected 1", inReady); end
    endtask

    task automatic test_max_operands();
        @(negedge clk);
        inValid = 1'b1; a = 6'd63; b = 6'd63; cin = 1'b1; outReady = 1'b1;
        #1;
        total++; if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL max_in_ready: got %b expected 1", inReady); end
        @(negedge clk);
        idleInputs();
        #1;
        total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL max_early_valid: got %b expected 0", outValid); end
        @(negedge clk); #1;
        total++; if (outValid !== 1'b1 || product !== 12'hF82) begin
            bad++; $display("[TB] FAIL max_product: got valid=%b %0h expected valid=1 f82", outValid, product);
        end
        @(negedge clk); #1;
        total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL max_drain: got %b expected 0", outValid); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        inValid = 1'b1; a = 6'd5; b = 6'd7; cin = 1'b0; outReady = 1'b1;
        @(negedge clk);
        a = 6'd10; b = 6'd12; cin = 1'b1;
        @(negedge clk);
        idleInputs();
        #1;
        total++; if (outValid !== 1'b1 || product !== 12'd35) begin
            bad++; $display("[TB] FAIL b2b_first: got valid=%b %0d expected valid=1 35", outValid, product);
        end
        @(negedge clk); #1;
        total++; if (outValid !== 1'b1 || product !== 12'd121) begin
            bad++; $display("[TB] FAIL b2b_second: got valid=%b %0d expected valid=1 121", outValid, product);
        end
        @(negedge clk); #1;
        total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drain: got %b expected 0", outValid); end
    endtask

    task automatic test_stall();
        logic [W-1:0] sa[3] = '{6'd3, 6'd9, 6'd50};
        logic [W-1:0] sb[3] = '{6'd4, 6'd9, 6'd2};
        logic         sc[3] = '{1'b0, 1'b1, 1'b1};
        logic [PW-1:0] firstExp, exp;
        int idx = 0;
        int got = 0;
        expQ.delete();
        firstExp = refProduct(sa[0], sb[0], sc[0], 1'b0);
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            @(negedge clk);
            if (idx < 3) begin
                inValid = 1'b1; a = sa[idx]; b = sb[idx]; cin = sc[idx];
            end else begin
                idleInputs();
            end
            outReady = (cyc >= 4);
            #1;
            if (cyc == 2 || cyc == 3) begin
                total++; if (inReady !== 1'b0) begin bad++; $display("[TB] FAIL stall_in_ready: got %b expected 0", inReady); end
                total++; if (outValid !== 1'b1 || product !== firstExp) begin
                    bad++; $display("[TB] FAIL stall_hold: got valid=%b %0h expected valid=1 %0h", outValid, product, firstExp);
                end
            end
            if (cyc == 3) begin
                total++; if (idx != 2) begin bad++; $display("[TB] FAIL stall_accepts: got %0d expected 2", idx); end
            end
            if (outValid === 1'b1 && outReady) begin
                exp = expQ.pop_front();
                total++; if (product !== exp) begin bad++; $display("[TB] FAIL stall_order: got %0h expected %0h", product, exp); end
                got++;
            end
            if (inValid && inReady === 1'b1) begin
                expQ.push_back(refProduct(a, b, cin, 1'b0));
                idx++;
            end
        end
        total++; if (got != 3) begin bad++; $display("[TB] FAIL stall_timeout: got %0d results expected 3", got); end
        idleInputs();
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        inValid = 1'b1; a = 6'd21; b = 6'd33; cin = 1'b0; outReady = 1'b0;
        @(negedge clk);
        a = 6'd17; b = 6'd40; cin = 1'b1;
        @(negedge clk);
        #1;
        total++; if (inReady !== 1'b0) begin bad++; $display("[TB] FAIL midrst_full: got in_ready=%b expected 0", inReady); end
        rst = 1'b1;
        #1;
        total++; if (outValid !== 1'b0 || product !== '0) begin
            bad++; $display("[TB] FAIL midrst_clear: got valid=%b %0h expected valid=0 0", outValid, product);
        end
        @(negedge clk);
        rst = 1'b0;
        idleInputs();
        outReady = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk); #1;
            total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_stale: got %b expected 0 (cycle %0d)", outValid, cyc); end
        end
        expQ.delete();
    endtask

`ifdef CSR_MULT_SIGNED_EN
    task automatic test_signed();
        logic [W-1:0]  sa[3] = '{6'h20, 6'h20, 6'h20};
        logic [W-1:0]  sb[3] = '{6'h1F, 6'h20, 6'h1F};
        logic          ss[3] = '{1'b1, 1'b1, 1'b0};
        logic [PW-1:0] want[3] = '{12'hC20, 12'h400, 12'h3E0};
        int idx = 0;
        int got = 0;
        for (int cyc = 0; cyc < 12 && got < 3; cyc++) begin
            @(negedge clk);
            if (idx < 3) begin
                inValid = 1'b1; a = sa[idx]; b = sb[idx]; cin = 1'b0; sgn = ss[idx];
            end else begin
                idleInputs();
            end
            outReady = 1'b1;
            #1;
            if (outValid === 1'b1) begin
                total++; if (product !== want[got]) begin bad++; $display("[TB] FAIL signed_%0d: got %0h expected %0h", got, product, want[got]); end
                got++;
            end
            if (inValid && inReady === 1'b1) idx++;
        end
        total++; if (got != 3) begin bad++; $display("[TB] FAIL signed_timeout: got %0d results expected 3", got); end
        idleInputs();
    endtask
`endif

    task automatic test_random();
        localparam int N = 2000;
        logic [PW-1:0] exp;
        logic expReady;
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        expQ.delete();
        while ((sent < N || got < sent) && cyc < 20 * N) begin
            @(negedge clk);
            inValid  = (sent < N) && ($urandom_range(0, 3) != 0);
            a        = W'($urandom);
            b        = W'($urandom);
            cin      = 1'($urandom);
`ifdef CSR_MULT_SIGNED_EN
            sgn      = 1'($urandom);
`else
            sgn      = 1'b0;
`endif
            outReady = ($urandom_range(0, 9) < 7);
            #1;
            expReady = (expQ.size() < 2) || outReady;
            total++; if (inReady !== expReady) begin
                bad++; $display("[TB] FAIL rand_in_ready: got %b expected %b (cycle %0d)", inReady, expReady, cyc);
            end
            if (outValid === 1'b1 && outReady) begin
                if (expQ.size() == 0) begin
                    total++; bad++; $display("[TB] FAIL rand_spurious: got %0h expected no result", product);
                end else begin
                    exp = expQ.pop_front();
                    total++; if (product !== exp) begin bad++; $display("[TB] FAIL rand_product: got %0h expected %0h", product, exp); end
                    got++;
                end
            end
            if (inValid && inReady === 1'b1) begin
                expQ.push_back(refProduct(a, b, cin, sgn));
                sent++;
            end
            cyc++;
        end
        total++; if (sent != N || got != sent) begin
            bad++; $display("[TB] FAIL rand_timeout: got sent=%0d done=%0d expected %0d", sent, got, N);
        end
        idleInputs();
    endtask

    initial begin
        test_reset();
        test_max_operands();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
`ifdef CSR_MULT_SIGNED_EN
        test_signed();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion expected finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
